spi_transaction_sequencer: RTL

Command front-end for the half-duplex SPI master, in the fabric_clk domain. It buffers SPI transaction commands and issues each one to the master as a single-cycle `transaction_length` strobe. After each issue it enforces a per-command settle gap, so the master's internal command FIFO is never overrun. When the gap expires it samples the master's read-data register and returns the result on a valid/ready response port for every command that contains read bits.

---
 rtl/spi_transaction_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_transaction_sequencer.sv
// -----------------------------------------------------------------------------
// spi_transaction_sequencer
//
// Command front-end for the half-duplex SPI master (fabric_clk domain).
// Commands are buffered in a small FIFO. Each valid command is issued to the
// master as a one-cycle nonzero mst_transaction_length strobe. The sequencer
// then waits a per-command settle gap so the master's own command FIFO is
// never overrun. When a command contains read bits, the master's read-data
// register is sampled at the end of the gap and returned on a valid/ready
// response port.
//
// Ports
//   fabric_clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command push handshake (ready = FIFO not full)
//   cmd_length, cmd_data,
//   cmd_mask, cmd_cpol,
//   cmd_cpha, cmd_gap            command fields (mask: 1 = write bit, MSB-first)
//   mst_transaction_length       one-cycle issue strobe to the master
//   mst_transaction_data,
//   mst_rw_mask, mst_cpol,
//   mst_cpha                     held from one issue until the next
//   mst_read_data                master's transaction_read_data
//   rsp_valid / rsp_ready,
//   rsp_data                     read-data response handshake
//   busy                         FSM active or FIFO non-empty
//   cmd_count                    FIFO occupancy
//   err_len / err_clr            sticky invalid-length flag and its clear
// -----------------------------------------------------------------------------
module spi_transaction_sequencer #(
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 6,
    parameter int GAP_WIDTH             = 16,
    parameter int CMD_DEPTH             = 4
) (
    input  logic                             fabric_clk,
    input  logic                             reset_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
    input  logic [DATA_WIDTH-1:0]            cmd_data,
    input  logic [DATA_WIDTH-1:0]            cmd_mask,
    input  logic                             cmd_cpol,
    input  logic                             cmd_cpha,
    input  logic [GAP_WIDTH-1:0]             cmd_gap,
    output logic [TRANSACTION_LEN_WIDTH-1:0] mst_transaction_length,
    output logic [DATA_WIDTH-1:0]            mst_transaction_data,
    output logic [DATA_WIDTH-1:0]            mst_rw_mask,
    output logic                             mst_cpol,
    output logic                             mst_cpha,
    input  logic [DATA_WIDTH-1:0]            mst_read_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             busy,
    output logic [$clog2(CMD_DEPTH):0]       cmd_count,
    output logic                             err_len,
    input  logic                             err_clr
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = TRANSACTION_LEN_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Valid lengths are 1..DATA_WIDTH.
    function automatic logic len_ok(input logic [TW-1:0] len);
        return (len != '0) && (int'(len) <= DATA_WIDTH);
    endfunction

    // Any mask bit that is 0 inside the top 'len' bits is a read bit.
    function automatic logic calc_has_read(input logic [TW-1:0] len,
                                           input logic [DATA_WIDTH-1:0] mask);
        logic [DATA_WIDTH-1:0] m;
        m = len_ok(len) ? ~({DATA_WIDTH{1'b1}} >> len) : '0;
        return |(~mask & m);
    endfunction

    // Command FIFO storage (data only, no reset needed)
    logic [TW-1:0]         r_fifo_len      [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data     [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_mask     [CMD_DEPTH];
    logic                  r_fifo_cpol     [CMD_DEPTH];
    logic                  r_fifo_cpha     [CMD_DEPTH];
    logic [GAP_WIDTH-1:0]  r_fifo_gap      [CMD_DEPTH];
    logic                  r_fifo_has_read [CMD_DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t                r_state;
    logic [TW-1:0]         r_mst_len;
    logic [DATA_WIDTH-1:0] r_mst_data;
    logic [DATA_WIDTH-1:0] r_mst_mask;
    logic                  r_mst_cpol;
    logic                  r_mst_cpha;
    logic [GAP_WIDTH-1:0]  r_gap_cnt;
    logic                  r_has_read;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_err_len;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head_ok;

    assign w_full    = (r_count == CW'(CMD_DEPTH));
    assign w_empty   = (r_count == '0);
    // The full flag is the only input to ready; a same-cycle pop never
    // makes room for a push.
    assign w_push    = cmd_valid & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_head_ok = len_ok(r_fifo_len[r_rd_ptr]);

    always_ff @(posedge fabric_clk) begin
        if (w_push) begin
            r_fifo_len[r_wr_ptr]      <= cmd_length;
            r_fifo_data[r_wr_ptr]     <= cmd_data;
            r_fifo_mask[r_wr_ptr]     <= cmd_mask;
            r_fifo_cpol[r_wr_ptr]     <= cmd_cpol;
            r_fifo_cpha[r_wr_ptr]     <= cmd_cpha;
            r_fifo_gap[r_wr_ptr]      <= cmd_gap;
            r_fifo_has_read[r_wr_ptr] <= calc_has_read(cmd_length, cmd_mask);
        end
    end

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_mst_len   <= '0;
            r_mst_data  <= '0;
            r_mst_mask  <= '0;
            r_mst_cpol  <= 1'b0;
            r_mst_cpha  <= 1'b0;
            r_gap_cnt   <= '0;
            r_has_read  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err_len   <= 1'b0;
        end else begin
            // Strobe defaults low so it is never high for more than one cycle.
            r_mst_len <= '0;

            if (err_clr)
                r_err_len <= 1'b0;
            else if (w_pop && !w_head_ok)
                r_err_len <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    // Invalid heads are dropped here without touching mst_*.
                    if (w_pop && w_head_ok) begin
                        r_mst_len  <= r_fifo_len[r_rd_ptr];
                        r_mst_data <= r_fifo_data[r_rd_ptr];
                        r_mst_mask <= r_fifo_mask[r_rd_ptr];
                        r_mst_cpol <= r_fifo_cpol[r_rd_ptr];
                        r_mst_cpha <= r_fifo_cpha[r_rd_ptr];
                        r_gap_cnt  <= r_fifo_gap[r_rd_ptr];
                        r_has_read <= r_fifo_has_read[r_rd_ptr];
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end else if (r_has_read) begin
                        r_rsp_data  <= mst_read_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready              = ~w_full;
    assign cmd_count              = r_count;
    assign busy                   = (r_state != S_IDLE) | ~w_empty;
    assign mst_transaction_length = r_mst_len;
    assign mst_transaction_data   = r_mst_data;
    assign mst_rw_mask            = r_mst_mask;
    assign mst_cpol               = r_mst_cpol;
    assign mst_cpha               = r_mst_cpha;
    assign rsp_valid              = r_rsp_valid;
    assign rsp_data               = r_rsp_data;
    assign err_len                = r_err_len;

endmodule
